// File: rtl/cotm32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cotm32_pkg
//  Brief    : Shared constants and types for the cotm32 core.
//  Revision : 1.0  initial release
// ============================================================================
package cotm32_pkg;

    // Instruction memory size in bytes
    localparam int unsigned MEM_SIZE         = 1024;
    // Width of one instruction word
    localparam int unsigned INST_WIDTH       = 32;
    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    // Default boot address of the fetch unit
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch control states
    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage : cotm32_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Brief    : IF/ID valid/ready handshake carrying the fetched entry.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
    import cotm32_pkg::*;

    logic                  valid;
    logic                  ready;
    logic [31:0]           pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  fault;

    // Producer side (fetch)
    modport master (
        output valid,
        output pc,
        output inst,
        output fault,
        input  ready
    );

    // Consumer side (decode)
    modport slave (
        input  valid,
        input  pc,
        input  inst,
        input  fault,
        output ready
    );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/inst_mem.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem
//  Brief    : Word-organised instruction memory with combinational read and
//             a synchronous load port used to preload the program.
//  Revision : 1.0  initial release
// ============================================================================
module inst_mem
    import cotm32_pkg::*;
#(
    parameter int unsigned MEM_SIZE_P = cotm32_pkg::MEM_SIZE,
    localparam int unsigned ADDR_W    = $clog2(MEM_SIZE_P),
    localparam int unsigned WORDS     = MEM_SIZE_P / 4
) (
    input  wire logic                  i_clk,
    input  wire logic [ADDR_W-1:0]     i_addr,
    output logic      [INST_WIDTH-1:0] o_inst,
    input  wire logic                  i_we,
    input  wire logic [ADDR_W-3:0]     i_waddr,
    input  wire logic [INST_WIDTH-1:0] i_wdata
);

    logic [INST_WIDTH-1:0] mem_q [WORDS];
    logic [ADDR_W-3:0]     word_addr;

    // Byte offset is ignored: reads always return the containing word
    assign word_addr = (ADDR_W-2)'(i_addr >> 2);
    assign o_inst    = mem_q[word_addr];

    // Program load port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

endmodule : inst_mem
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : IF stage. Owns the PC, addresses inst_mem combinationally and
//             registers (pc, inst, fault) into the IF/ID handshake entry.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit
    import cotm32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = cotm32_pkg::RESET_PC_DEFAULT,
    parameter int unsigned MEM_SIZE  = cotm32_pkg::MEM_SIZE,
    localparam int unsigned ADDR_W   = $clog2(MEM_SIZE)
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst_n,
    output logic      [ADDR_W-1:0]     o_imem_addr,
    input  wire logic [INST_WIDTH-1:0] i_imem_inst,
    input  wire logic                  i_redirect,
    input  wire logic [31:0]           i_redirect_pc,
    fetch_unit_if.master               if_id
);

    fetch_state_t          state_q;
    logic [31:0]           pc_q;
    logic                  valid_q;
    logic [31:0]           out_pc_q;
    logic [INST_WIDTH-1:0] out_inst_q;
    logic                  out_fault_q;

    logic                  advance;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  fault;
    logic [31:0]           pc_inc;

    // Entry slot may be refilled when empty or being consumed this cycle
    assign advance      = !valid_q || if_id.ready;
    assign misaligned   = (pc_q[1:0] != 2'b00);
    assign out_of_range = ((pc_q >> ADDR_W) != 32'd0);
    assign fault        = misaligned || out_of_range;
    assign pc_inc       = pc_q + 32'd4;

    // Memory sees the truncated PC even for faulting addresses
    assign o_imem_addr  = pc_q[ADDR_W-1:0];

    assign if_id.valid  = valid_q;
    assign if_id.pc     = out_pc_q;
    assign if_id.inst   = out_inst_q;
    assign if_id.fault  = out_fault_q;

    // Fetch FSM: BOOT gives one idle cycle after reset, RUN streams entries
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
            out_pc_q    <= 32'd0;
            out_inst_q  <= NOP_INST;
            out_fault_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    if (i_redirect) begin
                        pc_q <= i_redirect_pc;
                    end
                end
                RUN: begin
                    if (i_redirect) begin
                        // Redirect wins over a same-cycle handoff; held entry is dropped
                        valid_q <= 1'b0;
                        pc_q    <= i_redirect_pc;
                    end else if (advance) begin
                        valid_q     <= 1'b1;
                        out_pc_q    <= pc_q;
                        pc_q        <= pc_inc;
                        out_fault_q <= fault;
                        out_inst_q  <= fault ? NOP_INST : i_imem_inst;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Directed self-checking bench for fetch_unit with inst_mem.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    import cotm32_pkg::*;

    localparam int unsigned ADDR_W = $clog2(MEM_SIZE);

    logic                  clk;
    logic                  rst_n;
    logic [ADDR_W-1:0]     imem_addr;
    logic [INST_WIDTH-1:0] imem_inst;
    logic                  redirect;
    logic [31:0]           redirect_pc;
    logic                  we;
    logic [ADDR_W-3:0]     waddr;
    logic [INST_WIDTH-1:0] wdata;

    int n_total;
    int n_bad;

    fetch_unit_if if_id ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MEM_SIZE (MEM_SIZE)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_addr   (imem_addr),
        .i_imem_inst   (imem_inst),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .if_id         (if_id)
    );

    inst_mem #(
        .MEM_SIZE_P (MEM_SIZE)
    ) u_mem (
        .i_clk   (clk),
        .i_addr  (imem_addr),
        .o_inst  (imem_inst),
        .i_we    (we),
        .i_waddr (waddr),
        .i_wdata (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Memory word i holds A0A0_0000 | i
    function automatic logic [31:0] mw(input int i);
        return 32'hA0A0_0000 | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic entry(input string tag, input logic [31:0] pc,
                         input logic [31:0] inst, input logic fault);
        chk({tag, ".valid"}, 32'(if_id.valid), 32'd1);
        chk({tag, ".pc"},    if_id.pc,         pc);
        chk({tag, ".inst"},  if_id.inst,       inst);
        chk({tag, ".fault"}, 32'(if_id.fault), 32'(fault));
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        if_id.ready = 1'b1;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;

        // Preload while fetch is held in reset
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            we    = 1'b1;
            waddr = (ADDR_W-2)'(i);
            wdata = mw(i);
            @(negedge clk);
        end
        we = 1'b0;

        // Reset values
        chk("rst.valid", 32'(if_id.valid), 32'd0);
        chk("rst.pc",    if_id.pc,         32'd0);
        chk("rst.inst",  if_id.inst,       NOP_INST);
        chk("rst.fault", 32'(if_id.fault), 32'd0);
        chk("rst.addr",  32'(imem_addr),   32'd0);

        // Release: BOOT cycle, then streaming
        rst_n = 1'b1;
        tick();
        chk("boot.valid", 32'(if_id.valid), 32'd0);
        tick(); entry("s0", 32'h0, mw(0), 1'b0);
        tick(); entry("s1", 32'h4, mw(1), 1'b0);
        tick(); entry("s2", 32'h8, mw(2), 1'b0);
        tick(); entry("s3", 32'hC, mw(3), 1'b0);

        // Backpressure on (4,A1)
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        chk("bp.redir.valid", 32'(if_id.valid), 32'd0);
        redirect = 1'b0;
        tick(); entry("bp.e0", 32'h0, mw(0), 1'b0);
        tick(); entry("bp.e1", 32'h4, mw(1), 1'b0);
        if_id.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp.addr", 32'(imem_addr), 32'h8);
            tick();
            entry("bp.hold", 32'h4, mw(1), 1'b0);
        end
        chk("bp.addr.end", 32'(imem_addr), 32'h8);
        if_id.ready = 1'b1;
        tick(); entry("bp.e2", 32'h8, mw(2), 1'b0);
        tick(); entry("bp.e3", 32'hC, mw(3), 1'b0);

        // Redirect while holding (4,A1)
        redirect = 1'b1; redirect_pc = 32'h4;
        tick();
        redirect = 1'b0;
        tick(); entry("rh.e1", 32'h4, mw(1), 1'b0);
        if_id.ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h10;
        tick();
        chk("rh.valid", 32'(if_id.valid), 32'd0);
        chk("rh.pc",    if_id.pc,         32'h4);
        chk("rh.inst",  if_id.inst,       mw(1));
        redirect = 1'b0; if_id.ready = 1'b1;
        tick(); entry("rh.t0", 32'h10, mw(4), 1'b0);
        tick(); entry("rh.t1", 32'h14, mw(5), 1'b0);

        // Misaligned target
        redirect = 1'b1; redirect_pc = 32'h6;
        tick();
        chk("mis.valid", 32'(if_id.valid), 32'd0);
        chk("mis.addr",  32'(imem_addr),   32'h6);
        redirect = 1'b0;
        tick(); entry("mis.e0", 32'h6, NOP_INST, 1'b1);
        chk("mis.addr2", 32'(imem_addr), 32'hA);
        tick(); entry("mis.e1", 32'hA, NOP_INST, 1'b1);

        // Out of range
        redirect = 1'b1; redirect_pc = 32'h400;
        tick();
        chk("oor.addr", 32'(imem_addr), 32'h0);
        redirect = 1'b0;
        tick(); entry("oor.e0", 32'h400, NOP_INST, 1'b1);
        tick(); entry("oor.e1", 32'h404, NOP_INST, 1'b1);

        // Wrap-around
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick(); entry("wrap.e0", 32'hFFFF_FFFC, NOP_INST, 1'b1);
        chk("wrap.addr", 32'(imem_addr), 32'h0);
        tick(); entry("wrap.e1", 32'h0, mw(0), 1'b0);

        // Asynchronous reset during streaming
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(if_id.valid), 32'd0);
        chk("arst.pc",    if_id.pc,         32'd0);
        chk("arst.inst",  if_id.inst,       NOP_INST);
        chk("arst.addr",  32'(imem_addr),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst.boot", 32'(if_id.valid), 32'd0);
        tick(); entry("arst.e0", 32'h0, mw(0), 1'b0);

        // Redirect taken during BOOT
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        chk("bootr.valid", 32'(if_id.valid), 32'd0);
        chk("bootr.addr",  32'(imem_addr),   32'h20);
        redirect = 1'b0;
        tick(); entry("bootr.e0", 32'h20, mw(8), 1'b0);
        tick(); entry("bootr.e1", 32'h24, mw(9), 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the cotm32 core, directly upstream of inst_mem.
- Owns the program counter and drives inst_mem's i_addr combinationally from it.
- Captures the returned o_inst together with its PC into an IF/ID output register and hands it to decode with a valid/ready handshake.
- Accepts redirects (branch, jump, trap) from later stages, flushing any held entry.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- MEM_SIZE, cotm32_pkg::MEM_SIZE, instruction memory size in bytes; sets ADDR_W = $clog2(MEM_SIZE).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- o_imem_addr  output  ADDR_W  address to inst_mem.i_addr; equals pc[ADDR_W-1:0], combinational from the PC register.
- i_imem_inst  input  INST_WIDTH  inst_mem.o_inst; combinational response to o_imem_addr.
- i_redirect  input  1  load a new PC this cycle and flush the output register.
- i_redirect_pc  input  32  target PC for i_redirect.
- o_valid  output  1  IF/ID entry valid.
- i_ready  input  1  decode accepts the entry this cycle.
- o_pc  output  32  PC of the held entry.
- o_inst  output  INST_WIDTH  instruction of the held entry.
- o_fault  output  1  held entry is a fetch fault (misaligned or out of range).

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - state=BOOT, pc=RESET_PC, o_valid=0, o_pc=0, o_inst=NOP_INST (32'h0000_0013), o_fault=0.
- States:
  - BOOT: no capture; o_valid stays 0. Always goes to RUN on the next edge, which gives one clean cycle after reset release.
  - If i_redirect is high in BOOT, pc <= i_redirect_pc and the state still goes to RUN.
- RUN, advance = !o_valid || i_ready.
  - i_redirect=1 (highest priority, regardless of advance or i_ready):
    - o_valid <= 0, pc <= i_redirect_pc, o_pc/o_inst/o_fault unchanged.
    - The held entry is dropped even if i_ready=1 that cycle; decode must ignore it.
  - else if advance:
    - o_valid <= 1, o_pc <= pc, pc <= pc + 4 (modulo 2^32).
    - fault = (pc[1:0] != 0) || (pc[31:ADDR_W] != 0).
    - o_fault <= fault; o_inst <= fault ? NOP_INST : i_imem_inst.
  - else (o_valid && !i_ready): hold. pc, o_pc, o_inst, o_fault are all stable; no new capture.
- Throughput: one instruction per cycle while i_ready=1.
- Latency:
  - Redirect at edge N: the target's entry is valid after edge N+1, so there is one bubble cycle.
  - Reset release: first entry is valid after the second rising edge.
- Fault handling:
  - A fault is not sticky. A faulting PC still advances by 4; it is the trap unit's job to redirect.
  - o_imem_addr still drives the truncated pc; inst_mem's output is discarded.
- Wrap-around: pc=32'hFFFF_FFFC advances to 32'h0000_0000. 32'hFFFF_FFFC itself faults when out of range.
- Reset mid-operation: immediate return to the reset values, and any in-flight redirect is lost.
- Outputs come straight from registers, except o_imem_addr, which is combinational from the pc register only.

Decomposition:
- cotm32_pkg additions:
  - NOP_INST constant (32'h0000_0013).
  - fetch_state_t enum {BOOT, RUN}.
  - RESET_PC_DEFAULT constant.
- ADDR_W is a localparam derived from MEM_SIZE.
- No sub-module. inst_mem stays a sibling instance in the core top. The tb instantiates both fetch_unit and inst_mem, with the memory preloaded.

Test Plan:
- Reset release with i_ready=1 and memory words 0..3 = A0,A1,A2,A3:
  - o_valid rises after the 2nd edge.
  - Sequence (o_pc, o_inst) = (0,A0), (4,A1), (8,A2), (C,A3) on consecutive cycles; o_fault=0.
- Backpressure: hold i_ready=0 for 3 cycles while o_pc=4.
  - o_pc=4 and o_inst=A1 stay stable, o_imem_addr stays at 8.
  - On i_ready=1 the next entry is (8,A2) with nothing skipped or duplicated.
- Redirect to 32'h10 while holding (4,A1) with i_ready=0:
  - Next cycle o_valid=0.
  - The following cycle gives (10, mem[4]), then (14, mem[5]).
- Misaligned redirect to 32'h6:
  - Entry is (6, NOP_INST) with o_fault=1.
  - The next entry is (A, NOP_INST) with o_fault=1.
- Out-of-range: redirect to MEM_SIZE, with MEM_SIZE=1024 giving 32'h400:
  - Entry is o_fault=1 and o_inst=32'h0000_0013.
  - Redirect to 32'hFFFF_FFFC: a fault entry, then o_pc=0 with o_fault=1 only if out of range; for pc=0 expect o_fault=0.
- Asynchronous reset asserted mid-cycle during streaming:
  - o_valid drops immediately, without waiting for a clock edge.
  - After release the bench checks BOOT, then (RESET_PC, mem[0]).
